// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the UART instruction loader.
// LOADER_CHECKSUM_EN adds the CHECK state for the trailing XOR checksum byte.
package instr_loader_pkg;

  localparam int DEFAULT_MEM_WORDS = 256;
  localparam int COUNT_W           = 16;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {CNT_HI, CNT_LO, DATA, CHECK, DONE, ERR} state_t;
`else
  typedef enum logic [2:0] {CNT_HI, CNT_LO, DATA, DONE, ERR} state_t;
`endif

endpackage

// File: rtl/loader_word_packer.sv
// Shifts received bytes MSB-first into a 32-bit word.
// word_ready flags the cycle in which the 4th byte arrives.
module loader_word_packer
  import instr_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_ready
);

  logic [23:0] shift_reg;
  logic [1:0]  byte_cnt_reg;

  // The completed word includes the byte arriving this cycle.
  assign word       = {shift_reg, byte_data};
  assign word_ready = byte_valid && (byte_cnt_reg == 2'd3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg    <= '0;
      byte_cnt_reg <= '0;
    end else if (clear) begin
      shift_reg    <= '0;
      byte_cnt_reg <= '0;
    end else if (byte_valid) begin
      shift_reg    <= {shift_reg[15:0], byte_data};
      byte_cnt_reg <= byte_cnt_reg + 2'd1;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Loads a count-prefixed word stream from the UART into instruction memory.
// Optional macro LOADER_CHECKSUM_EN: expects a trailing XOR checksum byte.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int          MEM_WORDS = DEFAULT_MEM_WORDS,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        load_req,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  localparam logic [COUNT_W:0] MAX_N = (COUNT_W + 1)'(MEM_WORDS);

`ifdef LOADER_CHECKSUM_EN
  localparam state_t AFTER_DATA = CHECK;
  logic [7:0] xor_reg;
`else
  localparam state_t AFTER_DATA = DONE;
`endif

  state_t             state_reg, state_next;
  logic [COUNT_W-1:0] count_reg;
  logic [COUNT_W-1:0] word_cnt_reg;
  logic [COUNT_W-1:0] n_rx;
  logic               accept_byte;
  logic               byte_valid;
  logic               word_ready;
  logic               last_word;
  logic [31:0]        word;

  // load_req takes priority over any byte arriving in the same cycle.
  assign accept_byte = rx_valid && !load_req;
  assign byte_valid  = accept_byte && (state_reg == DATA);
  assign n_rx        = {count_reg[COUNT_W-1:8], rx_data};
  assign last_word   = (word_cnt_reg == count_reg - COUNT_W'(1));

  loader_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (load_req),
    .byte_valid (byte_valid),
    .byte_data  (rx_data),
    .word       (word),
    .word_ready (word_ready)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= CNT_HI;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    cpu_hold   = 1'b1;
    done       = 1'b0;
    error      = 1'b0;
    case (state_reg)
      CNT_HI: if (accept_byte) state_next = CNT_LO;
      CNT_LO: begin
        if (accept_byte) begin
          if (n_rx == '0)                  state_next = AFTER_DATA;
          else if ({1'b0, n_rx} > MAX_N)   state_next = ERR;
          else                             state_next = DATA;
        end
      end
      DATA: if (word_ready && last_word) state_next = AFTER_DATA;
`ifdef LOADER_CHECKSUM_EN
      CHECK: if (accept_byte) state_next = (rx_data == xor_reg) ? DONE : ERR;
`endif
      DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
      end
      ERR: error = 1'b1;
      default: state_next = CNT_HI;
    endcase
    if (load_req) state_next = CNT_HI;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg    <= '0;
      word_cnt_reg <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= BASE_ADDR;
      imem_wdata   <= '0;
    end else begin
      imem_we <= 1'b0;
      if (load_req) begin
        count_reg    <= '0;
        word_cnt_reg <= '0;
      end else begin
        if (state_reg == CNT_HI && rx_valid) count_reg <= {rx_data, 8'h00};
        if (state_reg == CNT_LO && rx_valid) count_reg <= n_rx;
        if (word_ready) begin
          imem_we      <= 1'b1;
          imem_wdata   <= word;
          imem_addr    <= BASE_ADDR + {{(30 - COUNT_W){1'b0}}, word_cnt_reg, 2'b00};
          word_cnt_reg <= word_cnt_reg + COUNT_W'(1);
        end
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running XOR of every byte before the trailer, count bytes included.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xor_reg <= '0;
    end else if (load_req) begin
      xor_reg <= '0;
    end else if (accept_byte &&
                 (state_reg == CNT_HI || state_reg == CNT_LO || state_reg == DATA)) begin
      xor_reg <= xor_reg ^ rx_data;
    end
  end
`endif

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: table of byte streams plus hand-written
// sequences for reset mid-word, load_req collision, and the 256-word boundary.
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        load_req;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  instr_loader #(.MEM_WORDS(256), .BASE_ADDR(32'h0000_0000)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .load_req   (load_req),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] waddr_q[$];
  logic [31:0] wdata_q[$];
  logic [7:0]  cks;

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      waddr_q.push_back(imem_addr);
      wdata_q.push_back(imem_wdata);
    end
  end

  typedef struct {
    logic [95:0] bytes;
    int          n;
    int          nw;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        exp_done;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    cks      = cks ^ b;
    tick(1);
    rx_valid = 1'b0;
    if (gap > 0) tick(gap);
  endtask

  task restart();
    load_req = 1'b1;
    tick(1);
    load_req = 1'b0;
    cks = 8'h00;
    waddr_q.delete();
    wdata_q.delete();
  endtask

  task finish_stream();
`ifdef LOADER_CHECKSUM_EN
    send_byte(cks, 0);
`endif
    tick(3);
  endtask

  function automatic logic [31:0] wa(input int k);
    return (k < waddr_q.size()) ? waddr_q[k] : 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] wd(input int k);
    return (k < wdata_q.size()) ? wdata_q[k] : 32'hxxxx_xxxx;
  endfunction

  task check_status(input string tag, input int nw, input logic d, input logic e);
    $display("%s: writes=%0d done=%0b error=%0b cpu_hold=%0b",
             tag, waddr_q.size(), done, error, cpu_hold);
    check({tag, ".writes"}, 32'(waddr_q.size()), 32'(nw));
    check({tag, ".done"}, {31'd0, done}, {31'd0, d});
    check({tag, ".error"}, {31'd0, error}, {31'd0, e});
    check({tag, ".cpu_hold"}, {31'd0, cpu_hold}, {31'd0, ~d});
  endtask

  initial begin
    vecs[0] = '{96'h00_02_3C_0D_40_00_AD_A0_00_08_00_00, 10, 2, 32'h3C0D4000, 32'hADA00008, 1'b1, 1'b0};
    vecs[1] = '{96'h01_01_00_00_00_00_00_00_00_00_00_00,  2, 0, 32'h0,        32'h0,        1'b0, 1'b1};
    vecs[2] = '{96'h00_00_00_00_00_00_00_00_00_00_00_00,  2, 0, 32'h0,        32'h0,        1'b1, 1'b0};
    vecs[3] = '{96'h00_01_08_00_00_10_00_00_00_00_00_00,  6, 1, 32'h08000010, 32'h0,        1'b1, 1'b0};
    vecs[4] = '{96'h00_01_DE_AD_BE_EF_00_00_00_00_00_00,  6, 1, 32'hDEADBEEF, 32'h0,        1'b1, 1'b0};
    vecs[5] = '{96'h80_00_00_00_00_00_00_00_00_00_00_00,  2, 0, 32'h0,        32'h0,        1'b0, 1'b1};

    reset = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; load_req = 1'b0; cks = 8'h00;
    tick(2);
    $display("reset: we=%0b addr=%h wdata=%h hold=%0b done=%0b error=%0b",
             imem_we, imem_addr, imem_wdata, cpu_hold, done, error);
    check("reset.we", {31'd0, imem_we}, 32'd0);
    check("reset.addr", imem_addr, 32'h0);
    check("reset.wdata", imem_wdata, 32'h0);
    check("reset.hold", {31'd0, cpu_hold}, 32'd1);
    check("reset.done", {31'd0, done}, 32'd0);
    check("reset.error", {31'd0, error}, 32'd0);
    reset = 1'b0;
    tick(1);

    for (int v = 0; v < 6; v++) begin
      restart();
      for (int i = 0; i < vecs[v].n; i++) send_byte(vecs[v].bytes[95 - 8*i -: 8], v % 2);
      finish_stream();
      check_status($sformatf("vec%0d", v), vecs[v].nw, vecs[v].exp_done, vecs[v].exp_err);
      for (int k = 0; k < vecs[v].nw; k++) begin
        check($sformatf("vec%0d.addr%0d", v, k), wa(k), 32'(4 * k));
        check($sformatf("vec%0d.data%0d", v, k), wd(k), (k == 0) ? vecs[v].d0 : vecs[v].d1);
      end
    end

    // Bytes arriving after DONE must be ignored.
    restart();
    send_byte(8'h00, 0); send_byte(8'h00, 0);
    finish_stream();
    for (int i = 0; i < 6; i++) send_byte(8'(i), 0);
    tick(3);
    check_status("done_ignore", 0, 1'b1, 1'b0);

    // Async reset after two data bytes drops the partial word.
    restart();
    send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    #3 reset = 1'b1;
    #1;
    check("midreset.we", {31'd0, imem_we}, 32'd0);
    check("midreset.hold", {31'd0, cpu_hold}, 32'd1);
    check("midreset.done", {31'd0, done}, 32'd0);
    tick(1);
    reset = 1'b0;
    cks = 8'h00;
    tick(1);
    check("midreset.nowrite", 32'(waddr_q.size()), 32'd0);
    send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'h08, 0);
    send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h10, 0);
    finish_stream();
    check_status("midreset", 1, 1'b1, 1'b0);
    check("midreset.addr0", wa(0), 32'h0);
    check("midreset.data0", wd(0), 32'h08000010);

    // load_req with a simultaneous 4th data byte: the byte is discarded.
    restart();
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
    rx_data = 8'h44; rx_valid = 1'b1; load_req = 1'b1;
    tick(1);
    rx_valid = 1'b0; load_req = 1'b0; cks = 8'h00;
    for (int i = 0; i < 6; i++) send_byte((i == 1) ? 8'h01 : 8'h00, 0);
    finish_stream();
    check_status("collision", 1, 1'b1, 1'b0);
    check("collision.addr0", wa(0), 32'h0);
    check("collision.data0", wd(0), 32'h0);

    // Largest legal load: 256 words, last address 0x3FC.
    restart();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    for (int w = 0; w < 256; w++) begin
      logic [31:0] word;
      word = 32'hA500_0000 | 32'(w);
      for (int b = 0; b < 4; b++) send_byte(word[31 - 8*b -: 8], 0);
    end
    finish_stream();
    check_status("n256", 256, 1'b1, 1'b0);
    check("n256.addr0", wa(0), 32'h0);
    check("n256.addr128", wa(128), 32'h200);
    check("n256.data128", wd(128), 32'hA500_0080);
    check("n256.addr255", wa(255), 32'h3FC);
    check("n256.data255", wd(255), 32'hA500_00FF);

`ifdef LOADER_CHECKSUM_EN
    restart();
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'h56, 0); send_byte(8'h78, 0);
    send_byte(8'h09, 0);
    tick(3);
    check_status("cks_good", 1, 1'b1, 1'b0);
    check("cks_good.data0", wd(0), 32'h12345678);

    restart();
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'h56, 0); send_byte(8'h78, 0);
    send_byte(8'h00, 0);
    tick(3);
    check_status("cks_bad", 1, 1'b0, 1'b1);
    check("cks_bad.data0", wd(0), 32'h12345678);

    restart();
    send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h01, 0);
    tick(3);
    check_status("cks_empty_bad", 0, 1'b0, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter: MEM_WORDS, 256, instruction memory depth in 32-bit words (word index = address bits [9:2]).
REQ-002 Parameter: BASE_ADDR, 32'h00000000, byte address of first word written.
REQ-003 Port: clk  input  1  the single clock; all state changes on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: rx_data  input  8  received byte from the UART receive path.
REQ-006 Port: rx_valid  input  1  one-cycle strobe; rx_data valid this cycle.
REQ-007 Port: load_req  input  1  one-cycle strobe; restart a load session.
REQ-008 Port: imem_we  output  1  instruction memory write enable, one cycle per word.
REQ-009 Port: imem_addr  output  32  byte address of the word written, word-aligned.
REQ-010 Port: imem_wdata  output  32  instruction word written.
REQ-011 Port: cpu_hold  output  1  keeps the pipeline in reset/stall while loading.
REQ-012 Port: done  output  1  level; load finished successfully.
REQ-013 Port: error  output  1  level; load aborted.

Function
REQ-014 The block SHALL accept the stream: count_hi, count_lo (16-bit word count N, big-endian), then N words of 4 bytes each, most significant byte first.
REQ-015 States SHALL be CNT_HI, CNT_LO, DATA, CHECK (macro only), DONE, ERR.
REQ-016 CNT_HI -> CNT_LO on rx_valid; CNT_LO -> DATA on rx_valid if 0 < N <= MEM_WORDS, -> DONE (or CHECK) if N == 0, -> ERR if N > MEM_WORDS.
REQ-017 In DATA, bytes SHALL be shifted into a 32-bit word register; a 2-bit byte counter wraps 3 -> 0.
REQ-018 On the 4th byte, imem_we SHALL pulse high for exactly the next cycle with imem_wdata = assembled word and imem_addr = BASE_ADDR + 4*k, k = words already written.
REQ-019 Word counter SHALL increment after each write; after word N-1 is written the state SHALL go to DONE (or CHECK) in the same cycle imem_we is high.
REQ-020 rx_valid in CNT_HI/CNT_LO/DATA SHALL be the only event advancing state; rx_valid in DONE or ERR SHALL be ignored.
REQ-021 cpu_hold SHALL be 1 in every state except DONE; done = 1 only in DONE; error = 1 only in ERR.
REQ-022 load_req in any state SHALL clear word/byte counters and go to CNT_HI next cycle; simultaneous rx_valid is discarded (load_req wins).
REQ-023 imem_we SHALL never be high outside DATA-sourced writes; imem_addr SHALL never exceed BASE_ADDR + 4*(MEM_WORDS-1).

Reset
REQ-024 reset SHALL asynchronously force state CNT_HI, counters 0, imem_we 0, imem_addr BASE_ADDR, imem_wdata 0, cpu_hold 1, done 0, error 0.
REQ-025 reset mid-word SHALL discard the partial word with no write.

Configuration
REQ-026 With LOADER_CHECKSUM_EN defined, one trailing byte SHALL follow the data; it SHALL equal the XOR of all preceding bytes including count bytes; match -> DONE, mismatch -> ERR (words already written remain).
REQ-027 Without LOADER_CHECKSUM_EN, CHECK SHALL not exist and the last data word SHALL lead directly to DONE.

Structure
REQ-028 Package instr_loader_pkg SHALL hold the state enumeration, default MEM_WORDS, and the count field width (16).
REQ-029 Byte-to-word assembly (shift register plus byte counter plus word-ready strobe) SHALL be sub-module loader_word_packer.

Verification
REQ-030 Bytes 00 02 3C 0D 40 00 AD A0 00 08 -> writes 32'h3C0D4000 @ 0x0 and 32'hADA00008 @ 0x4, done=1, cpu_hold=0.
REQ-031 Bytes 01 01 (N=257, MEM_WORDS=256) -> error=1, no imem_we, cpu_hold=1.
REQ-032 Bytes 00 00 -> done=1 with no write (checksum build: trailing 00 -> done, trailing 01 -> error).
REQ-033 Reset asserted after 2 of 4 data bytes -> no write, state CNT_HI; fresh stream 00 01 08 00 00 10 -> 32'h08000010 @ 0x0.
REQ-034 load_req in same cycle as rx_valid in DATA, then stream 00 01 00 00 00 00 -> single write 0 @ 0x0, done=1.
REQ-035 Checksum build: 00 01 12 34 56 78 plus trailer 09 -> done; trailer 00 -> error.
